// File: rtl/reed_solomon_frame_arbiter.sv
// Frame-level round-robin arbiter feeding two byte requesters into one RS decoder,
// with a tag FIFO that labels decoded output frames with their originating requester.
module reed_solomon_frame_arbiter #(
   parameter int unsigned N_IN      = 204,
   parameter int unsigned K_OUT     = 188,
   parameter int unsigned TAG_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a_data,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [7:0] b_data,
   input  logic       b_valid,
   output logic       b_ready,
   output logic [7:0] dec_data,
   output logic       dec_valid,
   input  logic [7:0] dec_out_data,
   input  logic       dec_out_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_id,
   output logic       out_last,
   output logic       busy,
   output logic       tag_err
);

   localparam int unsigned IN_W  = $clog2(N_IN);
   localparam int unsigned OUT_W = $clog2(K_OUT);
   localparam int unsigned PTR_W = $clog2(TAG_DEPTH);

   localparam logic [IN_W-1:0]  IN_LAST   = IN_W'(N_IN - 1);
   localparam logic [OUT_W-1:0] OUT_LAST  = OUT_W'(K_OUT - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(TAG_DEPTH);

   typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_t;

   state_t           state;
   logic             rr_b;      // 1: B has priority at the next contested grant
   logic [IN_W-1:0]  in_cnt;
   logic [OUT_W-1:0] out_cnt;
   logic             tag_mem [TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   tag_cnt;

   logic accept_a, accept_b, accept, in_last;
   logic fifo_full, fifo_empty;
   logic grant, grant_b;
   logic pop_ok, pop;

   always_comb begin
      accept_a   = a_valid && a_ready;
      accept_b   = b_valid && b_ready;
      accept     = accept_a || accept_b;
      in_last    = accept && (in_cnt == IN_LAST);
      fifo_full  = (tag_cnt == FIFO_FULL);
      fifo_empty = (tag_cnt == '0);
      grant      = (state == StIdle) && !fifo_full && (a_valid || b_valid);
      grant_b    = b_valid && (!a_valid || rr_b);
      pop_ok     = dec_out_valid && !fifo_empty;
      pop        = pop_ok && (out_cnt == OUT_LAST);
   end

   assign busy = (state != StIdle) || !fifo_empty;

   // Input side: grant FSM, byte counter and registered decoder feed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= StIdle;
         rr_b      <= 1'b0;
         a_ready   <= 1'b0;
         b_ready   <= 1'b0;
         in_cnt    <= '0;
         dec_valid <= 1'b0;
         dec_data  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (grant) begin
                  state   <= grant_b ? StGrantB : StGrantA;
                  a_ready <= !grant_b;
                  b_ready <= grant_b;
               end
            end
            StGrantA, StGrantB: begin
               if (in_last) begin
                  state   <= StIdle;
                  a_ready <= 1'b0;
                  b_ready <= 1'b0;
                  rr_b    <= (state == StGrantA);
               end
            end
            default: begin
               state   <= StIdle;
               a_ready <= 1'b0;
               b_ready <= 1'b0;
            end
         endcase
         dec_valid <= accept;
         if (accept) begin
            dec_data <= accept_b ? b_data : a_data;
            in_cnt   <= in_last ? '0 : in_cnt + IN_W'(1);
         end
      end
   end

   // Tag FIFO: one entry per granted frame, retired on the last decoded byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(TAG_DEPTH); i++) tag_mem[i] <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (grant) begin
            tag_mem[wr_ptr] <= grant_b;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({grant, pop})
            2'b10:   tag_cnt <= tag_cnt + (PTR_W + 1)'(1);
            2'b01:   tag_cnt <= tag_cnt - (PTR_W + 1)'(1);
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

   // Output side: bytes from the decoder are labelled with the FIFO head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_id    <= 1'b0;
         out_cnt   <= '0;
         tag_err   <= 1'b0;
      end else begin
         out_valid <= pop_ok;
         out_last  <= pop;
         if (pop_ok) begin
            out_data <= dec_out_data;
            out_id   <= tag_mem[rd_ptr];
            out_cnt  <= pop ? '0 : out_cnt + OUT_W'(1);
         end
         if (dec_out_valid && fifo_empty) tag_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reed_solomon_frame_arbiter.sv
// Self-checking bench: vector table, directed frame sequences and random traffic,
// all compared every cycle against a queue-based transaction model.
module tb_reed_solomon_frame_arbiter;

   localparam int N_IN = 204;
   localparam int K_OUT = 188;
   localparam int TAG_DEPTH = 4;

   logic clk, reset;
   logic [7:0] a_data, b_data, dec_out_data, dec_data, out_data;
   logic a_valid, b_valid, dec_out_valid;
   logic a_ready, b_ready, dec_valid, out_valid, out_id, out_last, busy, tag_err;
   logic [23:0] dut_bus;

   reed_solomon_frame_arbiter #(.N_IN(N_IN), .K_OUT(K_OUT), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .dec_data(dec_data), .dec_valid(dec_valid),
      .dec_out_data(dec_out_data), .dec_out_valid(dec_out_valid),
      .out_data(out_data), .out_valid(out_valid), .out_id(out_id), .out_last(out_last),
      .busy(busy), .tag_err(tag_err)
   );

   assign dut_bus = {a_ready, b_ready, dec_valid, dec_data, out_valid, out_data,
                     out_id, out_last, busy, tag_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pack(input logic ar, input logic br, input logic dv,
                                        input logic [7:0] dd, input logic ov,
                                        input logic [7:0] od, input logic oid,
                                        input logic ol, input logic bz, input logic te);
      return {ar, br, dv, dd, ov, od, oid, ol, bz, te};
   endfunction

   // Transaction model: who is streaming, bytes seen, and the queue of frame owners.
   int m_mode;      // 0 nobody, 1 A streaming, 2 B streaming
   int m_next_b;
   int m_in_seen;
   int m_out_seen;
   int m_tags[$];
   logic e_dec_valid, e_out_valid, e_out_id, e_out_last, e_tag_err;
   logic [7:0] e_dec_data, e_out_data;

   task automatic model_reset();
      m_mode = 0; m_next_b = 0; m_in_seen = 0; m_out_seen = 0;
      m_tags.delete();
      e_dec_valid = 0; e_out_valid = 0; e_out_id = 0; e_out_last = 0; e_tag_err = 0;
      e_dec_data = 0; e_out_data = 0;
   endtask

   function automatic logic [23:0] model_bus();
      return pack(m_mode == 1, m_mode == 2, e_dec_valid, e_dec_data, e_out_valid, e_out_data,
                  e_out_id, e_out_last, (m_mode != 0) || (m_tags.size() != 0), e_tag_err);
   endfunction

   task automatic model_edge();
      int pre_size;
      int who;
      bit acc;
      pre_size = m_tags.size();
      acc = (m_mode == 1 && a_valid) || (m_mode == 2 && b_valid);
      e_dec_valid = acc;
      if (acc) begin
         e_dec_data = (m_mode == 1) ? a_data : b_data;
         m_in_seen++;
         if (m_in_seen == N_IN) begin
            m_next_b = (m_mode == 1) ? 1 : 0;
            m_mode = 0;
            m_in_seen = 0;
         end
      end else if (m_mode == 0 && pre_size < TAG_DEPTH && (a_valid || b_valid)) begin
         who = (a_valid && b_valid) ? m_next_b : (b_valid ? 1 : 0);
         m_mode = who + 1;
         m_tags.push_back(who);
      end
      e_out_valid = 0;
      e_out_last = 0;
      if (dec_out_valid) begin
         if (pre_size == 0) e_tag_err = 1;
         else begin
            e_out_valid = 1;
            e_out_data = dec_out_data;
            e_out_id = (m_tags[0] != 0);
            m_out_seen++;
            if (m_out_seen == K_OUT) begin
               e_out_last = 1;
               m_out_seen = 0;
               void'(m_tags.pop_front());
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("cycle", {8'h0, dut_bus}, {8'h0, model_bus()});
   endtask

   task automatic idle_inputs();
      a_valid = 0; b_valid = 0; dec_out_valid = 0;
      a_data = 0; b_data = 0; dec_out_data = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      idle_inputs();
      #1;
      check("reset_outputs_zero", {8'h0, dut_bus}, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1;
   endtask

   typedef struct {
      logic av, bv, dov;
      logic [7:0] ad, bd, dod;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int cnt, overlap, busy_ready, id_bad, idx;
      logic pa, pb;
      int grants[$];
      int lasts[$];

      reset = 1;
      idle_inputs();
      #2;
      do_reset();

      // Hand-derived vectors from reset: orphan decoder byte, grant, accept, gap, output.
      tbl[0] = '{av:0, bv:0, dov:1, ad:8'h00, bd:8'h00, dod:8'h55,
                 exp:pack(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1)};
      tbl[1] = '{av:1, bv:0, dov:0, ad:8'h11, bd:8'h00, dod:8'h00,
                 exp:pack(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1)};
      tbl[2] = '{av:1, bv:0, dov:0, ad:8'h22, bd:8'h00, dod:8'h00,
                 exp:pack(1, 0, 1, 8'h22, 0, 8'h00, 0, 0, 1, 1)};
      tbl[3] = '{av:0, bv:0, dov:0, ad:8'h00, bd:8'h00, dod:8'h00,
                 exp:pack(1, 0, 0, 8'h22, 0, 8'h00, 0, 0, 1, 1)};
      tbl[4] = '{av:1, bv:1, dov:0, ad:8'h33, bd:8'h44, dod:8'h00,
                 exp:pack(1, 0, 1, 8'h33, 0, 8'h00, 0, 0, 1, 1)};
      tbl[5] = '{av:0, bv:1, dov:1, ad:8'h00, bd:8'h66, dod:8'h9a,
                 exp:pack(1, 0, 0, 8'h33, 1, 8'h9a, 0, 0, 1, 1)};
      tbl[6] = '{av:0, bv:0, dov:0, ad:8'h00, bd:8'h00, dod:8'h00,
                 exp:pack(1, 0, 0, 8'h33, 0, 8'h9a, 0, 0, 1, 1)};
      for (int i = 0; i < 7; i++) begin
         a_valid = tbl[i].av; b_valid = tbl[i].bv; dec_out_valid = tbl[i].dov;
         a_data = tbl[i].ad; b_data = tbl[i].bd; dec_out_data = tbl[i].dod;
         step();
         check($sformatf("vec%0d", i), {8'h0, dut_bus}, {8'h0, tbl[i].exp});
      end

      // Single A frame of 0x00..0xCB.
      do_reset();
      a_valid = 1;
      step();
      cnt = 0;
      for (int i = 0; i < N_IN; i++) begin
         a_data = 8'(i);
         step();
         if (dec_valid && dec_data == 8'(i)) cnt++;
      end
      a_valid = 0;
      step();
      check("a_frame_bytes", cnt, N_IN);
      check("a_frame_idle_ready", {a_ready, b_ready}, 2'b00);
      check("a_frame_busy_tag", busy, 1);

      // Both requesters held, decoder stalled: A,B,A,B then full FIFO blocks a 5th grant.
      do_reset();
      a_valid = 1; b_valid = 1;
      overlap = 0; busy_ready = 0; pa = 0; pb = 0;
      for (int i = 0; i < 900; i++) begin
         a_data = 8'($urandom); b_data = 8'($urandom);
         step();
         if (a_ready && b_ready) overlap++;
         if (a_ready && !pa) grants.push_back(0);
         if (b_ready && !pb) grants.push_back(1);
         pa = a_ready; pb = b_ready;
      end
      for (int i = 0; i < 40; i++) begin
         step();
         if (a_ready || b_ready) busy_ready++;
      end
      check("grant_count_full", grants.size(), 4);
      if (grants.size() >= 4)
         check("grant_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]},
               4'b0101);
      check("ready_while_full", busy_ready, 0);

      // Decoder drains two frames: first A then B; the freed slot lets A in again.
      dec_out_valid = 1;
      id_bad = 0; idx = 0;
      for (int i = 0; i < 2 * K_OUT; i++) begin
         dec_out_data = 8'($urandom);
         a_data = 8'($urandom); b_data = 8'($urandom);
         step();
         if (a_ready && b_ready) overlap++;
         if (a_ready && !pa) grants.push_back(0);
         if (b_ready && !pb) grants.push_back(1);
         pa = a_ready; pb = b_ready;
         if (out_valid) begin
            idx++;
            if (out_id != ((idx > K_OUT) ? 1'b1 : 1'b0)) id_bad++;
            if (out_last) lasts.push_back(idx);
         end
      end
      dec_out_valid = 0;
      step();
      check("ready_overlap", overlap, 0);
      check("out_bytes", idx, 2 * K_OUT);
      check("out_id_errors", id_bad, 0);
      check("out_last_count", lasts.size(), 2);
      if (lasts.size() == 2) begin
         check("out_last_pos0", lasts[0], K_OUT);
         check("out_last_pos1", lasts[1], 2 * K_OUT);
      end
      check("fifth_grant_seen", (grants.size() >= 5) ? grants[4] : -1, 0);
      check("no_tag_err", tag_err, 0);

      // Reset at byte 100 of a frame; the next frame must run a full N_IN bytes.
      do_reset();
      a_valid = 1;
      step();
      for (int i = 0; i < 100; i++) begin
         a_data = 8'(i);
         step();
      end
      do_reset();
      a_valid = 1;
      cnt = 0;
      for (int i = 0; i < N_IN + 1; i++) begin
         a_data = 8'($urandom);
         step();
         if (dec_valid) cnt++;
      end
      check("restart_bytes", cnt, N_IN);
      check("restart_ready_low", a_ready, 0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         a_valid = ($urandom_range(0, 3) != 0);
         b_valid = ($urandom_range(0, 2) != 0);
         a_data = 8'($urandom); b_data = 8'($urandom);
         dec_out_valid = ($urandom_range(0, 2) == 0);
         dec_out_data = 8'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
